// File: rtl/dsp_chain_fp16_operand_feeder_pkg.sv
// Shared widths, constants and packing helpers for the fp16 SOP2 chain feeder.
// Operand layout per stage is {top_a, top_b, bot_a, bot_b}, with top_a in the MSBs.
package dsp_chain_fp16_operand_feeder_pkg;

    localparam int FP16_W        = 16;
    localparam int FP32_W        = 32;
    localparam int OPS_PER_STAGE = 4;
    localparam int STAGE_OPS_W   = FP16_W * OPS_PER_STAGE;

    localparam logic [FP16_W-1:0] FP16_ZERO = 16'h0000;

    localparam int TOP_A_LSB = 3 * FP16_W;
    localparam int TOP_B_LSB = 2 * FP16_W;
    localparam int BOT_A_LSB = 1 * FP16_W;
    localparam int BOT_B_LSB = 0;

    function automatic int stage_lsb(input int k);
        return k * STAGE_OPS_W;
    endfunction

    function automatic logic [STAGE_OPS_W-1:0] pack_ops(
        input logic [FP16_W-1:0] top_a,
        input logic [FP16_W-1:0] top_b,
        input logic [FP16_W-1:0] bot_a,
        input logic [FP16_W-1:0] bot_b
    );
        logic [STAGE_OPS_W-1:0] p;
        p = '0;
        p[TOP_A_LSB +: FP16_W] = top_a;
        p[TOP_B_LSB +: FP16_W] = top_b;
        p[BOT_A_LSB +: FP16_W] = bot_a;
        p[BOT_B_LSB +: FP16_W] = bot_b;
        return p;
    endfunction

endpackage

// File: rtl/dsp_chain_result_fifo.sv
// Result FIFO: first-word fall-through, DEPTH entries of WIDTH bits.
// Latency: a push is visible at the head the cycle after the write edge.
// Backpressure: pop on empty is ignored; push on full is illegal and asserted against.
module dsp_chain_result_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_dat,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head_dat,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count_q;
    logic             do_pop;

    assign do_pop   = pop && !empty;
    assign empty    = (count_q == '0);
    assign full     = (count_q == (AW+1)'(DEPTH));
    assign count    = count_q;
    // Head reads as zero when empty so the port is clean straight out of reset.
    assign head_dat = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, do_pop})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assert property (@(posedge clk) disable iff (!reset) !(push && full));

endmodule

// File: rtl/dsp_chain_fp16_operand_feeder.sv
// Sequencer for an fp16 SOP2 DSP chain: skews operands per stage and collects fp32 results.
// Latency: stage k live at t+1+k*STAGE_LAT; result at FIFO head at t+2+(NUM_STAGES-1)*STAGE_LAT+RESULT_LAT.
// Backpressure: credit count caps in-flight + stored results at RES_DEPTH; in_ready drops at the cap.
module dsp_chain_fp16_operand_feeder
    import dsp_chain_fp16_operand_feeder_pkg::*;
#(
    parameter int NUM_STAGES = 4,
    parameter int STAGE_LAT  = 1,
    parameter int RESULT_LAT = 2,
    parameter int RES_DEPTH  = 8
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [NUM_STAGES*STAGE_OPS_W-1:0] in_ops,
    output logic [NUM_STAGES*STAGE_OPS_W-1:0] stage_ops,
    output logic [NUM_STAGES-1:0]             stage_op_valid,
    input  logic [FP32_W-1:0]                 chain_result,
    output logic                              res_valid,
    input  logic                              res_ready,
    output logic [FP32_W-1:0]                 res_data,
    output logic                              busy
);

    localparam int CW      = $clog2(RES_DEPTH) + 1;
    localparam int TAG_LAT = 1 + (NUM_STAGES - 1) * STAGE_LAT + RESULT_LAT;

    logic               accept;
    logic               pop;
    logic               fifo_empty;
    logic               fifo_full;
    logic [CW-1:0]      fifo_count;
    logic [CW-1:0]      credit_cnt;
    logic [TAG_LAT-1:0] tag_q;

    assign in_ready  = (credit_cnt < CW'(RES_DEPTH));
    assign accept    = in_valid && in_ready;
    assign pop       = res_valid && res_ready;
    assign res_valid = !fifo_empty;
    assign busy      = (credit_cnt != '0);

    // One delay line per stage; idle slots carry fp16 zeros so the chain sees +0.
    for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stage
        localparam int DLY = 1 + k * STAGE_LAT;
        localparam int LSB = stage_lsb(k);

        logic [STAGE_OPS_W-1:0] dly_dat [DLY];
        logic                   dly_vld [DLY];

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                for (int i = 0; i < DLY; i++) begin
                    dly_dat[i] <= {OPS_PER_STAGE{FP16_ZERO}};
                    dly_vld[i] <= 1'b0;
                end
            end else begin
                dly_vld[0] <= accept;
                dly_dat[0] <= accept ? in_ops[LSB +: STAGE_OPS_W] : {OPS_PER_STAGE{FP16_ZERO}};
                for (int i = 1; i < DLY; i++) begin
                    dly_vld[i] <= dly_vld[i-1];
                    dly_dat[i] <= dly_dat[i-1];
                end
            end
        end

        assign stage_ops[LSB +: STAGE_OPS_W] = dly_dat[DLY-1];
        assign stage_op_valid[k]             = dly_vld[DLY-1];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tag_q      <= '0;
            credit_cnt <= '0;
        end else begin
            tag_q <= {tag_q[TAG_LAT-2:0], accept};
            case ({accept, pop})
                2'b10:   credit_cnt <= credit_cnt + CW'(1);
                2'b01:   credit_cnt <= credit_cnt - CW'(1);
                default: credit_cnt <= credit_cnt;
            endcase
        end
    end

    dsp_chain_result_fifo #(
        .DEPTH (RES_DEPTH),
        .WIDTH (FP32_W)
    ) u_result_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (tag_q[TAG_LAT-1]),
        .push_dat (chain_result),
        .pop      (pop),
        .head_dat (res_data),
        .empty    (fifo_empty),
        .full     (fifo_full),
        .count    (fifo_count)
    );

    assert property (@(posedge clk) disable iff (!reset) credit_cnt <= CW'(RES_DEPTH));
    assert property (@(posedge clk) disable iff (!reset) fifo_count <= credit_cnt);
    assert property (@(posedge clk) disable iff (!reset) !(tag_q[TAG_LAT-1] && fifo_full && !pop));

endmodule
